mux_sel_arbiter: RTL

- Two-requester round-robin arbiter; drives the select line `s` of the downstream 2:1 mux (`s=0` passes input a, `s=1` passes input b).
- Converts independent requests from the two mux data sources into a registered, glitch-free select plus per-source grants.
- Sits directly upstream of the mux select input.

---
 rtl/mux_sel_arbiter_if.sv | 36 +++
 rtl/mux_sel_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter_if.sv
// Handshake bundle between the two mux data sources and the select arbiter.
// The master side (sources) drives requests; the slave side (arbiter) drives
// the mux select, the per-source grants, busy and the hold counter.
interface mux_sel_arbiter_if #(
   parameter int unsigned CNT_W = 4
) ();

   logic             req_a;
   logic             req_b;
   logic             s;
   logic             gnt_a;
   logic             gnt_b;
   logic             busy;
   logic [CNT_W-1:0] hold_cnt;

   modport master (
      output req_a,
      output req_b,
      input  s,
      input  gnt_a,
      input  gnt_b,
      input  busy,
      input  hold_cnt
   );

   modport slave (
      input  req_a,
      input  req_b,
      output s,
      output gnt_a,
      output gnt_b,
      output busy,
      output hold_cnt
   );

endinterface

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving the select line of a 2:1 mux
// (s=0 passes a, s=1 passes b). All outputs are registered so the select is
// glitch-free. Ties go to the source that was not granted last.
// Optional macro ARB_TIMEOUT_EN: forces a handover to the waiting source once
// the owner has held the path for MAX_HOLD cycles; without it the owner keeps
// the grant for as long as it requests and MAX_HOLD is ignored.
module mux_sel_arbiter #(
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   mux_sel_arbiter_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } state_e;

`ifdef ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(MAX_HOLD - 1);
`else
   localparam logic [CNT_W-1:0] HOLD_SAT = '1;
`endif

   state_e           state_q, state_d;
   logic             last_q,  last_d;
   logic             s_q,     s_d;
   logic             gnt_a_q, gnt_a_d;
   logic             gnt_b_q, gnt_b_d;
   logic             busy_q,  busy_d;
   logic [CNT_W-1:0] hold_q,  hold_d;
   logic             timeout;

   // Owner has reached its hold limit (only meaningful with the timeout feature)
   always_comb begin
`ifdef ARB_TIMEOUT_EN
      timeout = (hold_q == HOLD_SAT);
`else
      timeout = 1'b0;
`endif
   end

   // Next-state arbitration; outputs are derived from the state being entered
   // so that every output is a plain register with no decode after the flop.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req_a && bus.req_b) state_d = last_q ? GNT_A : GNT_B;
            else if (bus.req_a)         state_d = GNT_A;
            else if (bus.req_b)         state_d = GNT_B;
            else                        state_d = IDLE;
         end
         GNT_A: begin
            if (timeout && bus.req_b) state_d = GNT_B;
            else if (bus.req_a)       state_d = GNT_A;
            else if (bus.req_b)       state_d = GNT_B;
            else                      state_d = IDLE;
         end
         GNT_B: begin
            if (timeout && bus.req_a) state_d = GNT_A;
            else if (bus.req_b)       state_d = GNT_B;
            else if (bus.req_a)       state_d = GNT_A;
            else                      state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // hold counter restarts on any grant change and saturates while held
      if (state_d != IDLE && state_d == state_q)
         hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
      else
         hold_d = '0;

      // select and round-robin pointer only move when a grant is entered
      s_d    = s_q;
      last_d = last_q;
      if (state_d == GNT_A) begin
         s_d    = 1'b0;
         last_d = 1'b0;
      end else if (state_d == GNT_B) begin
         s_d    = 1'b1;
         last_d = 1'b1;
      end

      gnt_a_d = (state_d == GNT_A);
      gnt_b_d = (state_d == GNT_B);
      busy_d  = (state_d != IDLE);
   end

   // State and registered outputs; reset drops any grant immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         s_q     <= 1'b0;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         busy_q  <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         s_q     <= s_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
         busy_q  <= busy_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.s        = s_q;
   assign bus.gnt_a    = gnt_a_q;
   assign bus.gnt_b    = gnt_b_q;
   assign bus.busy     = busy_q;
   assign bus.hold_cnt = hold_q;

endmodule
